// File: rtl/tdm_demux_1to8.sv
// tdm_demux_1to8: splits a time-multiplexed stream of 8-slot frames onto
// eight parallel registered outputs. A sync-qualified beat marks slot 0;
// frames are assembled in a shadow buffer and published atomically.
module tdm_demux_1to8 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic             frame_valid,
  output logic             locked,
  output logic [2:0]       slot,
  output logic             sync_err,
  output logic [7:0]       err_cnt
);

  localparam int unsigned NSLOT  = 8;
  localparam int unsigned SLOT_W = 3;
  localparam int unsigned CNT_W  = 8;
  localparam logic [SLOT_W-1:0] SLOT_FIRST = SLOT_W'(0);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NSLOT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_nxt;

  // Decoded per-beat actions
  logic start_c;  // beat becomes slot 0 of a new frame
  logic store_c;  // beat stored into shadow slot 1..6
  logic done_c;   // slot-7 beat completes the frame
  logic err_c;    // sync violation on this beat

  logic [WIDTH-1:0] shadow_q [NSLOT-1];
  logic [WIDTH-1:0] out_q    [NSLOT];
  logic             frame_valid_q;
  logic             sync_err_q;
  logic             locked_q;
  logic [CNT_W-1:0] err_cnt_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic: sync beat locks, a missing sync at frame start unlocks
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      HUNT: begin
        if (in_valid && in_sync) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (in_valid && !in_sync && (slot_q == SLOT_FIRST)) begin
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Action decode and slot sequencing for the current beat
  always_comb begin
    start_c  = 1'b0;
    store_c  = 1'b0;
    done_c   = 1'b0;
    err_c    = 1'b0;
    slot_nxt = slot_q;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          slot_nxt = SLOT_FIRST;
          if (in_sync) begin
            start_c  = 1'b1;
            slot_nxt = SLOT_W'(1);
          end
        end
        LOCKED: begin
          if (in_sync) begin
            // Normal frame start at slot 0, resync anywhere else
            start_c  = 1'b1;
            err_c    = (slot_q != SLOT_FIRST);
            slot_nxt = SLOT_W'(1);
          end else if (slot_q == SLOT_FIRST) begin
            err_c    = 1'b1;
            slot_nxt = SLOT_FIRST;
          end else if (slot_q == SLOT_LAST) begin
            done_c   = 1'b1;
            slot_nxt = SLOT_FIRST;
          end else begin
            store_c  = 1'b1;
            slot_nxt = slot_q + SLOT_W'(1);
          end
        end
        default: begin
          slot_nxt = SLOT_FIRST;
        end
      endcase
    end
  end

  // Slot counter and locked flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= SLOT_FIRST;
      locked_q <= 1'b0;
    end else begin
      slot_q   <= slot_nxt;
      locked_q <= (state_nxt == LOCKED);
    end
  end

  // Shadow buffer collects slots 0..6 of the frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NSLOT - 1; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      if (start_c) begin
        shadow_q[0] <= in_data;
      end
      for (int unsigned i = 1; i < NSLOT - 1; i++) begin
        if (store_c && (slot_q == SLOT_W'(i))) begin
          shadow_q[i] <= in_data;
        end
      end
    end
  end

  // Publish the whole frame at once when its last beat arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        out_q[i] <= '0;
      end
    end else if (done_c) begin
      for (int unsigned i = 0; i < NSLOT - 1; i++) begin
        out_q[i] <= shadow_q[i];
      end
      out_q[NSLOT-1] <= in_data;
    end
  end

  // Single-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= done_c;
      sync_err_q    <= err_c;
    end
  end

  // Saturating sync-error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_c && (err_cnt_q != CNT_MAX)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign out0        = out_q[0];
  assign out1        = out_q[1];
  assign out2        = out_q[2];
  assign out3        = out_q[3];
  assign out4        = out_q[4];
  assign out5        = out_q[5];
  assign out6        = out_q[6];
  assign out7        = out_q[7];
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = locked_q;
  assign slot        = slot_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Testbench for tdm_demux_1to8: directed beat sequence, behavioural frame
// model and a scoreboard of expected published frames.
module tb_tdm_demux_1to8;

  localparam int unsigned W  = 16;
  localparam int unsigned FW = 8 * W;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_sync;
  logic [W-1:0]  out0, out1, out2, out3, out4, out5, out6, out7;
  logic          frame_valid;
  logic          locked;
  logic [2:0]    slot;
  logic          sync_err;
  logic [7:0]    err_cnt;

  tdm_demux_1to8 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sync     (in_sync),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .out4        (out4),
    .out5        (out5),
    .out6        (out6),
    .out7        (out7),
    .frame_valid (frame_valid),
    .locked      (locked),
    .slot        (slot),
    .sync_err    (sync_err),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model of the frame tracker
  logic          m_locked;
  int unsigned   m_slot;
  logic [W-1:0]  m_shadow [8];
  int unsigned   m_err_cnt;
  logic [FW-1:0] last_frame;
  logic [FW-1:0] sb_q [$];

  function automatic logic [FW-1:0] outs();
    return {out7, out6, out5, out4, out3, out2, out1, out0};
  endfunction

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked   = 1'b0;
    m_slot     = 0;
    m_err_cnt  = 0;
    last_frame = '0;
    for (int i = 0; i < 8; i++) m_shadow[i] = '0;
    sb_q.delete();
  endtask

  // Apply one cycle of input, advance the model, then check the DUT
  task automatic drive(input logic v, input logic [W-1:0] d, input logic s);
    logic          fv_e;
    logic          se_e;
    logic [FW-1:0] f;
    fv_e = 1'b0;
    se_e = 1'b0;
    in_valid = v;
    in_data  = d;
    in_sync  = s;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_shadow[0] = d; m_slot = 1; m_locked = 1'b1;
        end
      end else if (s) begin
        se_e = (m_slot != 0);
        m_shadow[0] = d; m_slot = 1;
      end else if (m_slot == 0) begin
        se_e = 1'b1; m_locked = 1'b0;
      end else if (m_slot == 7) begin
        for (int i = 0; i < 7; i++) f[i*W +: W] = m_shadow[i];
        f[7*W +: W] = d;
        sb_q.push_back(f);
        fv_e = 1'b1; m_slot = 0;
      end else begin
        m_shadow[m_slot] = d; m_slot++;
      end
      if (se_e && m_err_cnt < 255) m_err_cnt++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("frame_valid", FW'(frame_valid), FW'(fv_e));
    check("sync_err",    FW'(sync_err),    FW'(se_e));
    check("locked",      FW'(locked),      FW'(m_locked));
    check("slot",        FW'(slot),        FW'(m_slot));
    check("err_cnt",     FW'(err_cnt),     FW'(m_err_cnt));
    if (frame_valid) begin
      if (sb_q.size() == 0) begin
        check("frame_unexpected", FW'(1), FW'(0));
      end else begin
        last_frame = sb_q.pop_front();
        check("frame_data", outs(), last_frame);
      end
    end else begin
      check("out_hold", outs(), last_frame);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] base, input int unsigned gap);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, base + W'(i), (i == 0));
      for (int g = 0; g < int'(gap); g++) drive(1'b0, 16'hDEAD, 1'b1);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_sync  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs",     outs(),            '0);
    check("rst_fv",       FW'(frame_valid),  '0);
    check("rst_serr",     FW'(sync_err),     '0);
    check("rst_locked",   FW'(locked),       '0);
    check("rst_slot",     FW'(slot),         '0);
    check("rst_err_cnt",  FW'(err_cnt),      '0);
    rst_n = 1'b1;

    // Back-to-back frame, then the same frame with gaps between beats
    send_frame(16'h1000, 0);
    send_frame(16'h1000, 1);
    check("locked_after_frames", FW'(locked), FW'(1));

    // Frame aborted at slot 4 by a new sync beat
    for (int i = 0; i < 4; i++) drive(1'b1, 16'h3100 + W'(i), (i == 0));
    send_frame(16'h3000, 0);
    check("err_cnt_resync", FW'(err_cnt), FW'(1));

    // Missing sync after a complete frame drops lock, outputs hold
    drive(1'b1, 16'h5555, 1'b0);
    check("unlocked", FW'(locked), FW'(0));

    // Garbage before sync is discarded silently, then a good frame
    repeat (3) drive(1'b1, 16'hAAAA, 1'b0);
    send_frame(16'h2000, 0);

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 5; i++) drive(1'b1, 16'h6000 + W'(i), (i == 0));
    rst_n = 1'b0;
    #2;
    model_reset();
    check("arst_outs",    outs(),           '0);
    check("arst_fv",      FW'(frame_valid), '0);
    check("arst_locked",  FW'(locked),      '0);
    check("arst_slot",    FW'(slot),        '0);
    check("arst_err_cnt", FW'(err_cnt),     '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(16'h4000, 0);

    // Repeated resyncs drive the error counter into saturation
    for (int i = 0; i < 301; i++) drive(1'b1, W'(i), 1'b1);
    check("err_cnt_sat", FW'(err_cnt), FW'(255));
    check("no_new_frame", outs(), last_frame);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1to8.md
TDM_DEMUX_1TO8 -- requirements
Module: tdm_demux_1to8

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bit width of every data slot.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_data  input  WIDTH  slot data from the time-multiplexed stream.
REQ-005 SHALL have port in_valid  input  1  in_data/in_sync are a beat this cycle.
REQ-006 SHALL have port in_sync  input  1  marks the beat carrying slot 0; meaningful only with in_valid.
REQ-007 SHALL have ports out0..out7  output  WIDTH each  registered slot 0..7 of the last complete frame.
REQ-008 SHALL have port frame_valid  output  1  one-cycle pulse: out0..out7 just updated.
REQ-009 SHALL have port locked  output  1  high while in LOCKED state.
REQ-010 SHALL have port slot  output  3  index the next accepted beat will be written to.
REQ-011 SHALL have port sync_err  output  1  one-cycle pulse on sync violation.
REQ-012 SHALL have port err_cnt  output  8  saturating count of sync_err pulses.

Function
REQ-013 SHALL implement two states, HUNT and LOCKED; locked = (state==LOCKED), registered.
REQ-014 SHALL ignore all inputs on cycles with in_valid=0; counters, shadow and outputs hold (gaps of any length allowed).
REQ-015 In HUNT, beat with in_sync=0 SHALL be discarded, no error, state stays HUNT, slot=0.
REQ-016 In HUNT, beat with in_sync=1 SHALL store in_data as shadow slot 0, set slot=1, go LOCKED.
REQ-017 In LOCKED with slot=k (1..6) and in_sync=0, SHALL store in_data as shadow slot k, slot=k+1.
REQ-018 In LOCKED with slot=7 and in_sync=0, SHALL load out0..out6 from shadow and out7 from in_data on the same edge, pulse frame_valid the following cycle, set slot=0.
REQ-019 In LOCKED with slot=0 and in_sync=1, SHALL store beat as slot 0, slot=1 (normal frame start).
REQ-020 In LOCKED with slot=0 and in_sync=0, SHALL pulse sync_err, discard beat, go HUNT, slot=0.
REQ-021 In LOCKED with slot=1..7 and in_sync=1, SHALL pulse sync_err, discard partial frame, store beat as slot 0, slot=1, remain LOCKED (resync).
REQ-022 Outputs out0..out7 SHALL change only per REQ-018; aborted frames never reach outputs.
REQ-023 frame_valid and sync_err SHALL be exactly one cycle wide and never both high in one cycle.
REQ-024 err_cnt SHALL increment on each sync_err and saturate at 255 (no wrap).
REQ-025 Frame latency: frame_valid high in cycle N+1 where slot-7 beat is sampled at edge N.
REQ-026 Back-to-back frames (in_valid held high) SHALL sustain one beat per cycle with no dropped beats.

Reset
REQ-027 rst_n low SHALL immediately force: state HUNT, slot=0, out0..out7=0, shadow=0, frame_valid=0, sync_err=0, locked=0, err_cnt=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; after release, first in_sync beat starts a new frame.
REQ-029 Block SHALL accept a beat on the first rising edge after rst_n deasserts.

Verification
REQ-030 Reset, then 8 consecutive beats 0x1000..0x1007, sync on first -> frame_valid once, out0=0x1000..out7=0x1007, locked=1, err_cnt=0.
REQ-031 Same frame with in_valid low every other cycle -> identical outputs, frame_valid one cycle after the 0x1007 beat.
REQ-032 Three beats 0xAAAA before first sync, then valid frame 0x2000..0x2007 -> no sync_err, outputs 0x2000..0x2007.
REQ-033 Frame aborted at slot 4 by new sync beat 0x3000, followed by 0x3001..0x3007 -> sync_err once, err_cnt=1, outputs 0x3000..0x3007.
REQ-034 After complete frame, next beat has in_sync=0 -> sync_err, locked=0, outputs retain previous frame.
REQ-035 rst_n pulsed low at slot 5 -> all outputs 0 asynchronously; subsequent full frame 0x4000..0x4007 appears correctly; 300 forced violations -> err_cnt=255.
